// File: rtl/lib_voq_route_stage.sv
// Route stage in front of the virtual output queue. It decodes each packet's
// destination into a onehot VC request and buffers up to two packets
// (head + skid) so the VOQ can throttle without a combinational path upstream.
// Packets with an out-of-range destination are dropped and counted.

package lib_voq_route_pkg;
    localparam int DEST_W = 4;
    localparam int PAYLOAD_W = 12;

    typedef struct packed {
        logic [DEST_W-1:0]    dest;
        logic [PAYLOAD_W-1:0] payload;
    } packet_t;
endpackage

// state      | meaning
// ST_EMPTY   | head and skid invalid, upstream ready
// ST_HEAD    | head valid, skid empty, upstream ready
// ST_FULL    | head and skid valid, upstream stalled
module lib_voq_route_stage
    import lib_voq_route_pkg::*;
#(
    parameter int M     = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ce,
    input  packet_t          i_data,
    input  logic             i_data_val,
    output logic             o_en,
    output packet_t          o_data,
    output logic [0:M-1]     o_data_val,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_drop_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HEAD  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;

    packet_t        head_pkt;
    logic [0:M-1]   head_oh;
    packet_t        skid_pkt;
    logic [0:M-1]   skid_oh;
    logic [CNT_W-1:0] drop_cnt;

    logic           head_vld;
    logic           accept;
    logic           xfer;
    logic           in_legal;
    logic           acc_legal;
    logic           acc_drop;
    logic [31:0]    dest_ext;
    logic [0:M-1]   in_oh;

    logic           load_head_in;
    logic           load_head_skid;
    logic           load_skid;

    // Destination decode: range check and onehot VC request (bit d for dest d)
    always_comb begin
        dest_ext = {{(32 - DEST_W){1'b0}}, i_data.dest};
        in_legal = (dest_ext < 32'(M));
        in_oh    = '0;
        for (int i = 0; i < M; i++) begin
            in_oh[i] = (dest_ext == 32'(i));
        end
    end

    assign head_vld  = (state != ST_EMPTY);
    assign accept    = ce & i_data_val & o_en;
    assign xfer      = ce & head_vld & i_en;
    assign acc_legal = accept & in_legal;
    assign acc_drop  = accept & ~in_legal;

    // Occupancy state register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_EMPTY;
        end else if (ce) begin
            state <= state_nxt;
        end
    end

    // Next occupancy and which storage slot gets loaded this cycle
    always_comb begin
        state_nxt      = state;
        load_head_in   = 1'b0;
        load_head_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (acc_legal) begin
                    state_nxt    = ST_HEAD;
                    load_head_in = 1'b1;
                end
            end
            ST_HEAD: begin
                if (xfer) begin
                    if (acc_legal) begin
                        load_head_in = 1'b1;
                    end else begin
                        state_nxt = ST_EMPTY;
                    end
                end else if (acc_legal) begin
                    state_nxt = ST_FULL;
                    load_skid = 1'b1;
                end
            end
            ST_FULL: begin
                // upstream is stalled here, so only the skid can refill the head
                if (xfer) begin
                    state_nxt      = ST_HEAD;
                    load_head_skid = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_EMPTY;
            end
        endcase
    end

    // Outputs decoded from the occupancy register only, never from inputs
    always_comb begin
        o_en       = (state != ST_FULL);
        o_data_val = head_vld ? head_oh : '0;
        o_data     = head_pkt;
        o_drop_cnt = drop_cnt;
    end

    // Head and skid storage; head keeps its last packet after it drains
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            head_pkt <= '0;
            head_oh  <= '0;
            skid_pkt <= '0;
            skid_oh  <= '0;
        end else begin
            if (load_head_in) begin
                head_pkt <= i_data;
                head_oh  <= in_oh;
            end else if (load_head_skid) begin
                head_pkt <= skid_pkt;
                head_oh  <= skid_oh;
            end
            if (load_skid) begin
                skid_pkt <= i_data;
                skid_oh  <= in_oh;
            end
        end
    end

    // Saturating count of dropped out-of-range packets
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            drop_cnt <= '0;
        end else if (acc_drop && (drop_cnt != {CNT_W{1'b1}})) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_lib_voq_route_stage.sv
// Bench for lib_voq_route_stage: directed scenarios plus random traffic,
// checked every cycle against a queue-based model of the route stage.
module tb_lib_voq_route_stage;
    import lib_voq_route_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        ce;
    packet_t     i_data;
    logic        i_data_val;
    logic        i_en;

    logic        o_en;
    packet_t     o_data;
    logic [0:3]  o_data_val;
    logic [15:0] o_drop_cnt;

    logic        o_en2;
    packet_t     o_data2;
    logic [0:3]  o_data_val2;
    logic [1:0]  o_drop_cnt2;

    int n_pass;
    int n_total;

    packet_t mq[$];
    int      m_drops;
    packet_t m_odata;

    lib_voq_route_stage #(.M(4), .CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .ce(ce),
        .i_data(i_data), .i_data_val(i_data_val), .o_en(o_en),
        .o_data(o_data), .o_data_val(o_data_val), .i_en(i_en),
        .o_drop_cnt(o_drop_cnt)
    );

    lib_voq_route_stage #(.M(4), .CNT_W(2)) dut_sat (
        .clk(clk), .reset_n(reset_n), .ce(ce),
        .i_data(i_data), .i_data_val(i_data_val), .o_en(o_en2),
        .o_data(o_data2), .o_data_val(o_data_val2), .i_en(i_en),
        .o_drop_cnt(o_drop_cnt2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [0:3] onehot(input logic [3:0] d);
        logic [0:3] r;
        r = '0;
        r[d[1:0]] = 1'b1;
        return r;
    endfunction

    function automatic packet_t mk(input int d);
        packet_t p;
        p.dest    = 4'(d);
        p.payload = 12'($urandom);
        return p;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Model of one clock edge: a FIFO of at most two legal packets
    task automatic model_step();
        bit xf;
        bit ac;
        if (!reset_n) begin
            mq.delete();
            m_drops = 0;
            m_odata = '0;
        end else if (ce) begin
            xf = (mq.size() > 0) && i_en;
            ac = i_data_val && (mq.size() < 2);
            if (xf) void'(mq.pop_front());
            if (ac) begin
                if (i_data.dest < 4) mq.push_back(i_data);
                else if (m_drops < 65535) m_drops++;
            end
            if (mq.size() > 0) m_odata = mq[0];
        end
    endtask

    task automatic compare_all();
        logic [0:3] ev;
        ev = (mq.size() > 0) ? onehot(mq[0].dest) : 4'b0000;
        chk("o_en", 32'(o_en), 32'(mq.size() < 2));
        chk("o_data_val", 32'(o_data_val), 32'(ev));
        chk("o_data", 32'(o_data), 32'(m_odata));
        chk("o_drop_cnt", 32'(o_drop_cnt), 32'(m_drops));
        chk("o_drop_cnt_sat", 32'(o_drop_cnt2), 32'((m_drops > 3) ? 3 : m_drops));
        chk("o_data_val_sat", 32'(o_data_val2), 32'(ev));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        int n_xfer;
        n_pass = 0;
        n_total = 0;
        m_drops = 0;
        m_odata = '0;
        reset_n = 1'b0;
        ce = 1'b1;
        i_data = '0;
        i_data_val = 1'b0;
        i_en = 1'b0;

        // reset state
        cycle();
        cycle();
        reset_n = 1'b1;
        chk("rst_o_en", 32'(o_en), 32'd1);
        chk("rst_val", 32'(o_data_val), 32'd0);
        chk("rst_cnt", 32'(o_drop_cnt), 32'd0);
        chk("rst_data", 32'(o_data), 32'd0);

        // single packet, one-cycle latency
        i_en = 1'b1;
        i_data = mk(2);
        i_data_val = 1'b1;
        cycle();
        i_data_val = 1'b0;
        chk("t1_val", 32'(o_data_val), 32'(4'b0010));
        chk("t1_en", 32'(o_en), 32'd1);
        cycle();
        chk("t1_drain", 32'(o_data_val), 32'd0);

        // fill head and skid, third packet held upstream
        i_en = 1'b0;
        i_data = mk(0); i_data_val = 1'b1;
        cycle();
        i_data = mk(1);
        cycle();
        chk("t2_en_low", 32'(o_en), 32'd0);
        i_data = mk(3);
        cycle();
        cycle();
        chk("t2_head", 32'(o_data_val), 32'(4'b1000));
        i_en = 1'b1;
        cycle();
        chk("t2_second", 32'(o_data_val), 32'(4'b0100));
        cycle();
        i_data_val = 1'b0;
        chk("t2_third", 32'(o_data_val), 32'(4'b0001));
        cycle();
        chk("t2_empty", 32'(o_data_val), 32'd0);

        // 20-packet stream at full rate
        n_xfer = 0;
        for (int k = 0; k <= 20; k++) begin
            i_data_val = (k < 20);
            i_data = mk($urandom_range(0, 3));
            if ((|o_data_val) && i_en) n_xfer++;
            cycle();
        end
        i_data_val = 1'b0;
        chk("t3_xfers", 32'(n_xfer), 32'd20);

        // out-of-range drops and saturation of the narrow counter
        i_data = mk(5); i_data_val = 1'b1;
        cycle();
        i_data_val = 1'b0;
        chk("t4_val", 32'(o_data_val), 32'd0);
        chk("t4_cnt1", 32'(o_drop_cnt), 32'd1);
        for (int k = 0; k < 4; k++) begin
            i_data = mk($urandom_range(4, 15)); i_data_val = 1'b1;
            cycle();
        end
        i_data_val = 1'b0;
        chk("t4_cnt5", 32'(o_drop_cnt), 32'd5);
        chk("t4_sat", 32'(o_drop_cnt2), 32'd3);

        // reset with head and skid full
        i_en = 1'b0;
        i_data = mk(1); i_data_val = 1'b1;
        cycle();
        i_data = mk(2);
        cycle();
        i_data_val = 1'b0;
        reset_n = 1'b0;
        cycle();
        reset_n = 1'b1;
        chk("t5_val", 32'(o_data_val), 32'd0);
        chk("t5_en", 32'(o_en), 32'd1);
        chk("t5_cnt", 32'(o_drop_cnt), 32'd0);

        // ce low freezes everything
        i_data = mk(1); i_data_val = 1'b1;
        cycle();
        ce = 1'b0; i_en = 1'b1;
        i_data = mk(2);
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("t6_hold", 32'(o_data_val), 32'(4'b0100));
        end
        ce = 1'b1; i_data_val = 1'b0;
        cycle();
        chk("t6_resume", 32'(o_data_val), 32'd0);

        // random traffic
        for (int k = 0; k < 600; k++) begin
            reset_n    = ($urandom_range(0, 149) != 0);
            ce         = ($urandom_range(0, 7) != 0);
            i_data_val = $urandom_range(0, 1);
            i_en       = ($urandom_range(0, 2) != 0);
            i_data     = mk($urandom_range(0, 5));
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
